// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the default sizing and the controller state encoding.
package regfile_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_ZERO_REG   = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_e;

    // Pointer width for a requester count; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible requester at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_priority_picker
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic               o_valid_c
);

    // One extra bit so ptr+k cannot overflow before the wrap correction.
    logic [PTR_W:0] w_idx;

    always_comb begin
        o_grant_c = '0;
        o_valid_c = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!o_valid_c && i_eligible[w_idx[PTR_W-1:0]]) begin
                o_grant_c[w_idx[PTR_W-1:0]] = 1'b1;
                o_valid_c                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ requesters with
// round-robin selection; zero-register writes are acknowledged but suppressed.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ZERO_REG   = DEF_ZERO_REG
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    input  logic                          hold,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          regWrite,
    output logic [ADDR_WIDTH-1:0]         writeRegister,
    output logic [DATA_WIDTH-1:0]         writeData
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    arb_state_e             r_state;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_reg_write;
    logic [ADDR_WIDTH-1:0]  r_wr_reg;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic [PTR_W-1:0]       r_ptr;

    arb_state_e             w_state_nxt;
    logic [NUM_REQ-1:0]     w_ack_nxt;
    logic                   w_reg_write_nxt;
    logic [ADDR_WIDTH-1:0]  w_wr_reg_nxt;
    logic [DATA_WIDTH-1:0]  w_wr_data_nxt;
    logic [PTR_W-1:0]       w_ptr_nxt;

    logic [NUM_REQ-1:0]     w_eligible;
    logic [NUM_REQ-1:0]     w_pick_grant;
    logic                   w_pick_valid;
    logic                   w_grant;
    logic [PTR_W-1:0]       w_win_idx;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    // A requester being acked this cycle is masked so one request is never granted twice.
    assign w_eligible = req & ~r_ack;
    assign w_grant    = w_pick_valid & ~hold;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant_c  (w_pick_grant),
        .o_valid_c  (w_pick_valid)
    );

    // Encode the one-hot winner and mux its address/data slices.
    always_comb begin
        w_win_idx  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_win_idx  = PTR_W'(i);
                w_sel_addr = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; write port data holds when nothing is granted.
    always_comb begin
        w_state_nxt     = r_state;
        w_ack_nxt       = '0;
        w_reg_write_nxt = 1'b0;
        w_wr_reg_nxt    = r_wr_reg;
        w_wr_data_nxt   = r_wr_data;
        w_ptr_nxt       = r_ptr;

        if (w_grant) begin
            w_ack_nxt       = w_pick_grant;
            w_wr_reg_nxt    = w_sel_addr;
            w_wr_data_nxt   = w_sel_data;
            w_reg_write_nxt = (w_sel_addr != ADDR_WIDTH'(ZERO_REG));
            w_ptr_nxt       = (w_win_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_win_idx + PTR_W'(1);
        end

        case (r_state)
            IDLE:    if (w_grant)  w_state_nxt = WRITE;
            WRITE:   if (!w_grant) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ack       <= '0;
            r_reg_write <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_wr_reg    <= w_wr_reg_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign ack           = r_ack;
    assign regWrite      = r_reg_write;
    assign writeRegister = r_wr_reg;
    assign writeData     = r_wr_data;

endmodule
